// File: rtl/hack_kbd_pkg.sv
// Shared constants for the Hack keyboard: Hack key codes for the non-printing
// keys, the PS/2 set-2 prefix and shift scan codes, and the receive FSM states.
package hack_kbd_pkg;

  // Hack key codes for non-ASCII keys
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F2        = 16'd142;
  localparam logic [15:0] KEY_F3        = 16'd143;
  localparam logic [15:0] KEY_F4        = 16'd144;
  localparam logic [15:0] KEY_F5        = 16'd145;
  localparam logic [15:0] KEY_F6        = 16'd146;
  localparam logic [15:0] KEY_F7        = 16'd147;
  localparam logic [15:0] KEY_F8        = 16'd148;
  localparam logic [15:0] KEY_F9        = 16'd149;
  localparam logic [15:0] KEY_F10       = 16'd150;
  localparam logic [15:0] KEY_F11       = 16'd151;
  localparam logic [15:0] KEY_F12       = 16'd152;

  // PS/2 scan code set 2 special bytes
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Receive FSM states
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational US-layout keymap: (extended prefix, shift held, set-2 scan
// code) -> 16-bit Hack key code, 0 for any key without a Hack code.
module ps2_keymap
  import hack_kbd_pkg::*;
(
  input  logic        i_ext,
  input  logic        i_shift,
  input  logic [7:0]  i_code,
  output logic [15:0] o_key
);

  logic [15:0] w_pair;  // {shifted ASCII, unshifted ASCII}
  logic [15:0] w_key;

  // Printable keys: both ASCII variants, selected by shift afterwards
  always_comb begin
    w_pair = 16'd0;
    case (i_code)
      8'h1C: w_pair = {8'd65, 8'd97};
      8'h32: w_pair = {8'd66, 8'd98};
      8'h21: w_pair = {8'd67, 8'd99};
      8'h23: w_pair = {8'd68, 8'd100};
      8'h24: w_pair = {8'd69, 8'd101};
      8'h2B: w_pair = {8'd70, 8'd102};
      8'h34: w_pair = {8'd71, 8'd103};
      8'h33: w_pair = {8'd72, 8'd104};
      8'h43: w_pair = {8'd73, 8'd105};
      8'h3B: w_pair = {8'd74, 8'd106};
      8'h42: w_pair = {8'd75, 8'd107};
      8'h4B: w_pair = {8'd76, 8'd108};
      8'h3A: w_pair = {8'd77, 8'd109};
      8'h31: w_pair = {8'd78, 8'd110};
      8'h44: w_pair = {8'd79, 8'd111};
      8'h4D: w_pair = {8'd80, 8'd112};
      8'h15: w_pair = {8'd81, 8'd113};
      8'h2D: w_pair = {8'd82, 8'd114};
      8'h1B: w_pair = {8'd83, 8'd115};
      8'h2C: w_pair = {8'd84, 8'd116};
      8'h3C: w_pair = {8'd85, 8'd117};
      8'h2A: w_pair = {8'd86, 8'd118};
      8'h1D: w_pair = {8'd87, 8'd119};
      8'h22: w_pair = {8'd88, 8'd120};
      8'h35: w_pair = {8'd89, 8'd121};
      8'h1A: w_pair = {8'd90, 8'd122};
      8'h45: w_pair = {8'd41, 8'd48};
      8'h16: w_pair = {8'd33, 8'd49};
      8'h1E: w_pair = {8'd64, 8'd50};
      8'h26: w_pair = {8'd35, 8'd51};
      8'h25: w_pair = {8'd36, 8'd52};
      8'h2E: w_pair = {8'd37, 8'd53};
      8'h36: w_pair = {8'd94, 8'd54};
      8'h3D: w_pair = {8'd38, 8'd55};
      8'h3E: w_pair = {8'd42, 8'd56};
      8'h46: w_pair = {8'd40, 8'd57};
      8'h0E: w_pair = {8'd126, 8'd96};
      8'h4E: w_pair = {8'd95, 8'd45};
      8'h55: w_pair = {8'd43, 8'd61};
      8'h54: w_pair = {8'd123, 8'd91};
      8'h5B: w_pair = {8'd125, 8'd93};
      8'h5D: w_pair = {8'd124, 8'd92};
      8'h4C: w_pair = {8'd58, 8'd59};
      8'h52: w_pair = {8'd34, 8'd39};
      8'h41: w_pair = {8'd60, 8'd44};
      8'h49: w_pair = {8'd62, 8'd46};
      8'h4A: w_pair = {8'd63, 8'd47};
      8'h29: w_pair = {8'd32, 8'd32};
      default: w_pair = 16'd0;
    endcase
  end

  // Final lookup: E0-prefixed navigation keys, control/function keys, else ASCII
  always_comb begin
    w_key = 16'd0;
    if (i_ext) begin
      case (i_code)
        8'h6B:   w_key = KEY_LEFT;
        8'h75:   w_key = KEY_UP;
        8'h74:   w_key = KEY_RIGHT;
        8'h72:   w_key = KEY_DOWN;
        8'h6C:   w_key = KEY_HOME;
        8'h69:   w_key = KEY_END;
        8'h7D:   w_key = KEY_PGUP;
        8'h7A:   w_key = KEY_PGDN;
        8'h70:   w_key = KEY_INSERT;
        8'h71:   w_key = KEY_DELETE;
        default: w_key = 16'd0;
      endcase
    end else begin
      case (i_code)
        8'h5A:   w_key = KEY_NEWLINE;
        8'h66:   w_key = KEY_BACKSPACE;
        8'h76:   w_key = KEY_ESC;
        8'h05:   w_key = KEY_F1;
        8'h06:   w_key = KEY_F2;
        8'h04:   w_key = KEY_F3;
        8'h0C:   w_key = KEY_F4;
        8'h03:   w_key = KEY_F5;
        8'h0B:   w_key = KEY_F6;
        8'h83:   w_key = KEY_F7;
        8'h0A:   w_key = KEY_F8;
        8'h01:   w_key = KEY_F9;
        8'h09:   w_key = KEY_F10;
        8'h78:   w_key = KEY_F11;
        8'h07:   w_key = KEY_F12;
        default: w_key = {8'd0, (i_shift ? w_pair[15:8] : w_pair[7:0])};
      endcase
    end
  end

  assign o_key = w_key;

endmodule

// File: rtl/hack_keyboard.sv
// Hack KBD register (0x6000): PS/2 receiver with pin synchronizers and clock
// glitch filter, make/break decoder and held-key register.
// Optional build macro PS2_TIMEOUT_EN adds an idle timeout that aborts a
// partially received frame.
module hack_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 4
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  // Synchronizer and filter state
  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  // Receiver state
  rx_state_t     r_rx_state;
  logic [7:0]    r_rx_sr;
  logic [2:0]    r_bit_cnt;
  logic          r_rx_par;
  logic          r_byte_valid;
  logic [7:0]    r_byte;
  logic          r_frame_err;

  // Decoder state
  logic          r_brk, r_ext, r_shift;
  logic [8:0]    r_held;
  logic [15:0]   r_out;
  logic          r_strobe;
  logic [15:0]   w_key;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          r_filt_edge;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  assign w_timeout = (r_rx_state != RX_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
`endif

  // Two-flop synchronizers for both pins; idle PS/2 lines are high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Glitch filter: follow ps2_clk only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= {FW{1'b0}};
      r_fall     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      r_filt_edge <= 1'b0;
`endif
    end else begin
      r_fall <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      r_filt_edge <= 1'b0;
`endif
      if (r_clk_sync == r_filt_clk) begin
        r_filt_cnt <= {FW{1'b0}};
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_sync;
        r_filt_cnt <= {FW{1'b0}};
        r_fall     <= ~r_clk_sync;
`ifdef PS2_TIMEOUT_EN
        r_filt_edge <= 1'b1;
`endif
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  // Idle counter: cleared by any filtered clock edge or while idle, saturates at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= {TW{1'b0}};
    end else if (r_filt_edge || (r_rx_state == RX_IDLE)) begin
      r_to_cnt <= {TW{1'b0}};
    end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end
`endif

  // Receive FSM: start, 8 data bits LSB first, odd parity, stop; one-cycle result pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_sr      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_rx_par     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_fall) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!r_dat_sync) begin
              r_rx_state <= RX_DATA;
              r_bit_cnt  <= 3'd0;
            end
          end
          RX_DATA: begin
            r_rx_sr   <= {r_dat_sync, r_rx_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_state <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            r_rx_par   <= r_dat_sync;
            r_rx_state <= RX_STOP;
          end
          RX_STOP: begin
            if ((^{r_rx_sr, r_rx_par}) && r_dat_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_rx_sr;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      else if (w_timeout) begin
        r_rx_state  <= RX_IDLE;
        r_frame_err <= 1'b1;
      end
`endif
    end
  end

  ps2_keymap u_keymap (
    .i_ext   (r_ext),
    .i_shift (r_shift),
    .i_code  (r_byte),
    .o_key   (w_key)
  );

  // Decoder: prefix flags, shift tracking, last-make-wins held key, break release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      r_shift  <= 1'b0;
      r_held   <= 9'd0;
      r_out    <= 16'd0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_byte_valid) begin
        if (r_byte == PS2_BREAK) begin
          r_brk <= 1'b1;
        end else if (r_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (!r_ext && ((r_byte == PS2_LSHIFT) || (r_byte == PS2_RSHIFT))) begin
            r_shift <= ~r_brk;
          end else if (r_brk) begin
            // only releasing the key that is currently shown clears the register
            if ({r_ext, r_byte} == r_held) begin
              r_out  <= 16'd0;
              r_held <= 9'd0;
            end
          end else if (w_key != 16'd0) begin
            r_out    <= w_key;
            r_held   <= {r_ext, r_byte};
            r_strobe <= 1'b1;
          end
        end
      end
    end
  end

  assign out        = r_out;
  assign key_strobe = r_strobe;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_hack_keyboard.sv
// Directed bench for hack_keyboard: PS/2 frames driven bit by bit on the pins,
// key code and pulse counts checked against hand-computed values.
module tb_hack_keyboard;

  localparam int HALF = 200;  // PS/2 half period: 20 system clocks

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] out;
  logic        key_strobe;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobes = 0;
  int n_ferr = 0;
  int s_mark;
  int f_mark;

  hack_keyboard dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out        (out),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // count one-cycle pulses away from the active edge
  always @(negedge clk) begin
    if (key_strobe) n_strobes++;
    if (frame_err)  n_ferr++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive the first nbits of a frame {stop, parity, data, start}
  task automatic ps2_frame(input logic [7:0] b, input logic par_ok, input logic stop, input int nbits);
    logic [10:0] f;
    logic        p;
    p = par_ok ? ~(^b) : (^b);
    f = {stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    #(HALF);
    ps2_data = 1'b1;
    #(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_frame(b, 1'b1, 1'b1, 11);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_strobe", key_strobe, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // basic make
    s_mark = n_strobes;
    send(8'h1C); settle();
    check("make_a", out, 97);
    check("make_a_strobe", n_strobes - s_mark, 1);

    // reset in the middle of a frame, then a clean frame
    ps2_frame(8'h1C, 1'b1, 1'b1, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_out", out, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    s_mark = n_strobes;
    send(8'h1C); settle();
    check("after_rst_a", out, 97);
    check("after_rst_strobe", n_strobes - s_mark, 1);

    // break of the held key
    s_mark = n_strobes;
    send(8'hF0); send(8'h1C); settle();
    check("break_a", out, 0);
    check("break_no_strobe", n_strobes - s_mark, 0);

    // shift handling
    send(8'h12); send(8'h1C); settle();
    check("shift_A", out, 65);
    send(8'hF0); send(8'h1C); settle();
    check("shift_A_break", out, 0);
    send(8'hF0); send(8'h12); send(8'h1C); settle();
    check("unshift_a", out, 97);
    send(8'hF0); send(8'h1C); settle();
    send(8'h59); send(8'h16); settle();
    check("rshift_bang", out, 33);
    send(8'hF0); send(8'h16); send(8'hF0); send(8'h59); settle();
    check("bang_break", out, 0);

    // extended keys
    send(8'hE0); send(8'h75); settle();
    check("ext_up", out, 131);
    send(8'hE0); send(8'hF0); send(8'h75); settle();
    check("ext_up_break", out, 0);
    s_mark = n_strobes;
    send(8'h75); settle();
    check("kp8_unmapped", out, 0);
    check("kp8_no_strobe", n_strobes - s_mark, 0);
    send(8'hE0); send(8'h6B); settle();
    check("ext_left", out, 130);
    send(8'hE0); send(8'hF0); send(8'h6B); settle();
    send(8'h05); settle();
    check("f1", out, 141);
    send(8'h5A); settle();
    check("enter_over_f1", out, 128);
    send(8'hF0); send(8'h5A); settle();
    check("enter_break", out, 0);

    // rejected frames
    f_mark = n_ferr;
    ps2_frame(8'h1C, 1'b0, 1'b1, 11); settle();
    check("bad_par_ferr", n_ferr - f_mark, 1);
    check("bad_par_out", out, 0);
    f_mark = n_ferr;
    ps2_frame(8'h1C, 1'b1, 1'b0, 11); settle();
    check("bad_stop_ferr", n_ferr - f_mark, 1);
    check("bad_stop_out", out, 0);

    // overlap and repeat
    send(8'h1C); send(8'h32); settle();
    check("overlap_b", out, 98);
    send(8'hF0); send(8'h1C); settle();
    check("other_break", out, 98);
    s_mark = n_strobes;
    send(8'h32); send(8'h32); send(8'h32); settle();
    check("repeat_out", out, 98);
    check("repeat_strobes", n_strobes - s_mark, 3);

    // short ps2_clk glitch with data low must not start a frame
    f_mark = n_ferr;
    ps2_data = 1'b0;
    #(3);
    ps2_clk = 1'b0;
    #(20);
    ps2_clk = 1'b1;
    #(50);
    ps2_data = 1'b1;
    #(HALF);
    send(8'hF0); send(8'h32); settle();
    check("glitch_out", out, 0);
    check("glitch_ferr", n_ferr - f_mark, 0);

`ifdef PS2_TIMEOUT_EN
    f_mark = n_ferr;
    ps2_frame(8'h1C, 1'b1, 1'b1, 5);
    repeat (50100) @(negedge clk);
    check("timeout_ferr", n_ferr - f_mark, 1);
    send(8'h1C); settle();
    check("after_timeout", out, 97);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
